// File: rtl/wb_arbiter2_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM state codes
// (chosen to equal the one-hot grant) and Wishbone burst tag codes.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one Wishbone slave between two masters (LM32 I/D buses).
// Define WB_ARB_TIMEOUT_EN to add a stalled-slave watchdog that errors the granted master.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_lock_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_lock_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      gnt_o
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last_m1;
  logic       w_timeout;
  logic       w_unused;

  // Lock needs no handling: a grant is already held for as long as cyc stays high.
  assign w_unused = ^{m0_lock_i, m1_lock_i, 16'(TIMEOUT)};

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {r_state == GNT1, r_state == GNT0};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        if (w_state_next == GNT0) r_last_m1 <= 1'b0;
        if (w_state_next == GNT1) r_last_m1 <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = CTI_CLASSIC;
    s_bte_o  = BTE_LINEAR;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_state_next = r_last_m1 ? GNT0 : GNT1;
        else if (m0_cyc_i)        w_state_next = GNT0;
        else if (m1_cyc_i)        w_state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) w_state_next = m1_cyc_i ? GNT1 : IDLE;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i & ~w_timeout;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_timeout;
        m0_rty_o = s_rty_i;
      end
      GNT1: begin
        if (!m1_cyc_i) w_state_next = m0_cyc_i ? GNT0 : IDLE;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i & ~w_timeout;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_timeout;
        m1_rty_o = s_rty_i;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_req_stb;
  logic             w_term;
  logic             w_stall;

  assign w_req_stb = (r_state == GNT0 && m0_cyc_i && m0_stb_i) ||
                     (r_state == GNT1 && m1_cyc_i && m1_stb_i);
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = w_req_stb & ~w_term;
  // The clock on which the count would reach TIMEOUT is the one that fires.
  assign w_timeout = w_stall && (r_stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || w_term || w_timeout || (w_state_next != r_state)) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: scenario tasks push expected beats to a
// scoreboard queue that the slave model pops and checks at every termination.
module tb_wb_arbiter2;
  import wb_arbiter2_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO_CLKS = 8;
  localparam logic [1:0] RESP_ACK = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;
  localparam logic [1:0] RESP_RTY = 2'd3;

  typedef struct {
    logic [1:0]    gnt;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          we;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [1:0]    resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic          m_we  [2];
  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_lock[2];
  logic [2:0]    m_cti [2];
  logic [1:0]    m_bte [2];
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic s_we_o, s_cyc_o, s_stb_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;
  logic [DW-1:0] s_dat_i;
  logic s_ack_i, s_err_i, s_rty_i;
  logic [1:0] gnt_o;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  bit slave_stall = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO_CLKS)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m0_dat_o), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_lock_i(m_lock[0]),
    .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m1_dat_o), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_lock_i(m_lock[1]),
    .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  function automatic exp_t mk(input int m, input int beats, input logic [AW-1:0] base,
                              input int b, input logic [1:0] resp);
    exp_t e;
    e.gnt  = (m == 0) ? 2'b01 : 2'b10;
    e.adr  = base + AW'(4 * b);
    e.wdat = {base[15:0], 16'(b)} ^ 32'hA5A5_0000;
    e.rdat = ~e.adr;
    e.we   = (b % 2) == 1;
    e.sel  = (b == 0) ? 4'hF : SW'(b);
    e.cti  = (beats == 1) ? CTI_CLASSIC : ((b == beats - 1) ? CTI_EOB : CTI_INCR);
    e.bte  = base[9:8];
    e.resp = resp;
    return e;
  endfunction

  function automatic logic [2:0] resp3(input logic [1:0] r);
    return {r == RESP_ACK, r == RESP_ERR, r == RESP_RTY};
  endfunction

  function automatic logic m_term(input int m);
    return (m == 0) ? (m0_ack_o | m0_err_o | m0_rty_o) : (m1_ack_o | m1_err_o | m1_rty_o);
  endfunction

  task automatic drive_beat(input int m, input exp_t e, input logic lock);
    m_adr[m] = e.adr;  m_dat[m] = e.wdat; m_sel[m] = e.sel; m_we[m] = e.we;
    m_cti[m] = e.cti;  m_bte[m] = e.bte;  m_lock[m] = lock;
    m_cyc[m] = 1'b1;   m_stb[m] = 1'b1;
  endtask

  task automatic idle_master(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_lock[m] = 1'b0; m_we[m] = 1'b0;
    m_cti[m] = CTI_CLASSIC; m_bte[m] = BTE_LINEAR; m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0;
  endtask

  task automatic wait_term(input int m);
    int n = 0;
    bit ok = 1'b0;
    while (n < 64 && !ok) begin
      @(negedge clk);
      n++;
      ok = m_term(m);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL term_wait_m%0d got=no termination required=termination within 64 clocks", m);
    end
  endtask

  task automatic master_run(input int m, input int beats, input logic [AW-1:0] base, input logic lock);
    for (int b = 0; b < beats; b++) begin
      drive_beat(m, mk(m, beats, base, b, RESP_ACK), lock);
      wait_term(m);
      @(posedge clk); #1;
    end
    idle_master(m);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Slave: registered response one clock after seeing a strobe; checks each
  // completed beat against the front of the scoreboard.
  exp_t slv_e;
  logic [1:0] slv_resp;
  logic [DW-1:0] slv_dat;
  logic [2:0] exp_t0, exp_t1;
  initial begin : slave_model
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
    forever begin
      @(negedge clk);
      if (s_ack_i || s_err_i || s_rty_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=termination adr=%h required=no pending beat", s_adr_o);
        end else begin
          slv_e = sb_q.pop_front();
          exp_t0 = (slv_e.gnt == 2'b01) ? resp3(slv_e.resp) : 3'b000;
          exp_t1 = (slv_e.gnt == 2'b10) ? resp3(slv_e.resp) : 3'b000;
          $display("TXN gnt=%b adr=%h we=%b cti=%b resp=%0d", gnt_o, s_adr_o, s_we_o, s_cti_o, slv_e.resp);
          if (gnt_o !== slv_e.gnt) begin
            errors++; $display("FAIL sb_gnt got=%b required=%b", gnt_o, slv_e.gnt);
          end
          checks++;
          if (s_adr_o !== slv_e.adr) begin
            errors++; $display("FAIL sb_adr got=%h required=%h", s_adr_o, slv_e.adr);
          end
          checks++;
          if (s_dat_o !== slv_e.wdat) begin
            errors++; $display("FAIL sb_wdat got=%h required=%h", s_dat_o, slv_e.wdat);
          end
          checks++;
          if ({s_we_o, s_sel_o, s_cti_o, s_bte_o} !== {slv_e.we, slv_e.sel, slv_e.cti, slv_e.bte}) begin
            errors++;
            $display("FAIL sb_ctl got=%b_%b_%b_%b required=%b_%b_%b_%b", s_we_o, s_sel_o, s_cti_o, s_bte_o,
                     slv_e.we, slv_e.sel, slv_e.cti, slv_e.bte);
          end
          checks++;
          if ({s_cyc_o, s_stb_o} !== 2'b11) begin
            errors++; $display("FAIL sb_cyc_stb got=%b required=11", {s_cyc_o, s_stb_o});
          end
          checks++;
          if ({m0_ack_o, m0_err_o, m0_rty_o} !== exp_t0) begin
            errors++; $display("FAIL sb_m0_term got=%b required=%b", {m0_ack_o, m0_err_o, m0_rty_o}, exp_t0);
          end
          checks++;
          if ({m1_ack_o, m1_err_o, m1_rty_o} !== exp_t1) begin
            errors++; $display("FAIL sb_m1_term got=%b required=%b", {m1_ack_o, m1_err_o, m1_rty_o}, exp_t1);
          end
          checks++;
          if (m0_dat_o !== slv_e.rdat || m1_dat_o !== slv_e.rdat) begin
            errors++; $display("FAIL sb_rdat got=%h/%h required=%h", m0_dat_o, m1_dat_o, slv_e.rdat);
          end
        end
      end
      slv_resp = 2'd0;
      slv_dat  = s_dat_i;
      if (!rst_i && !slave_stall && s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i) && sb_q.size() > 0) begin
        slv_resp = sb_q[0].resp;
        slv_dat  = sb_q[0].rdat;
      end
      @(posedge clk); #1;
      s_ack_i = (slv_resp == RESP_ACK);
      s_err_i = (slv_resp == RESP_ERR);
      s_rty_i = (slv_resp == RESP_RTY);
      s_dat_i = slv_dat;
    end
  end

  task automatic test_reset();
    rst_i = 1'b1;
    idle_master(0); idle_master(1);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got=%b required=0000", {gnt_o, s_cyc_o, s_stb_o});
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) begin
      errors++; $display("FAIL reset_terms got=%b required=000000",
                         {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o});
    end
    @(posedge clk); #1;
    idle_master(0);
    rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({gnt_o, s_cyc_o} !== 3'b000) begin
        errors++; $display("FAIL reset_idle got=%b required=000", {gnt_o, s_cyc_o});
      end
    end
    $display("TXN reset done");
  endtask

  task automatic test_single();
    exp_t e;
    idle_cycles(1);
    e = mk(0, 1, 32'h100, 0, RESP_ACK);
    sb_q.push_back(e);
    drive_beat(0, e, 1'b0);
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      errors++; $display("FAIL single_c0 got=%b required=000", {gnt_o, s_cyc_o});
    end
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, m0_ack_o} !== 5'b01110 || s_adr_o !== 32'h100) begin
      errors++; $display("FAIL single_c1 got=%b adr=%h required=01110 adr=00000100",
                         {gnt_o, s_cyc_o, s_stb_o, m0_ack_o}, s_adr_o);
    end
    @(negedge clk);
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      errors++; $display("FAIL single_c2_ack got=%b required=10", {m0_ack_o, m1_ack_o});
    end
    @(posedge clk); #1;
    idle_master(0);
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0100) begin
      errors++; $display("FAIL single_release got=%b required=0100", {gnt_o, s_cyc_o, s_stb_o});
    end
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++; $display("FAIL single_idle got=%b required=00", gnt_o);
    end
  endtask

  task automatic test_simultaneous();
    idle_cycles(1);
    rst_i = 1'b1;
    idle_cycles(1);
    rst_i = 1'b0;
    sb_q.push_back(mk(0, 1, 32'h200, 0, RESP_ACK));
    sb_q.push_back(mk(1, 1, 32'h1200, 0, RESP_ACK));
    fork
      begin
        master_run(0, 1, 32'h200, 1'b0);
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b01) begin
          errors++; $display("FAIL simul_hold got=%b required=01", gnt_o);
        end
        @(negedge clk);
        checks++;
        if ({gnt_o, s_cyc_o} !== 3'b101) begin
          errors++; $display("FAIL simul_handover got=%b required=101", {gnt_o, s_cyc_o});
        end
      end
      master_run(1, 1, 32'h1200, 1'b0);
    join
  endtask

  task automatic test_round_robin();
    idle_cycles(2);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(0, 1, 32'h300 + AW'(16 * i), 0, RESP_ACK));
      sb_q.push_back(mk(1, 1, 32'h1300 + AW'(16 * i), 0, RESP_ACK));
    end
    fork
      for (int i = 0; i < 3; i++) begin
        master_run(0, 1, 32'h300 + AW'(16 * i), 1'b0);
        idle_cycles(1);
      end
      for (int j = 0; j < 3; j++) begin
        master_run(1, 1, 32'h1300 + AW'(16 * j), 1'b0);
        idle_cycles(1);
      end
    join
  endtask

  task automatic test_burst_lock();
    idle_cycles(3);
    for (int b = 0; b < 4; b++) sb_q.push_back(mk(1, 4, 32'h1500, b, RESP_ACK));
    sb_q.push_back(mk(0, 1, 32'h600, 0, RESP_ACK));
    fork
      master_run(1, 4, 32'h1500, 1'b1);
      begin
        idle_cycles(1);
        master_run(0, 1, 32'h600, 1'b0);
      end
    join
  endtask

  task automatic test_err_rty();
    idle_cycles(2);
    sb_q.push_back(mk(0, 1, 32'h700, 0, RESP_ERR));
    master_run(0, 1, 32'h700, 1'b0);
    idle_cycles(2);
    sb_q.push_back(mk(1, 1, 32'h1700, 0, RESP_RTY));
    master_run(1, 1, 32'h1700, 1'b0);
  endtask

  task automatic test_stall_timeout();
    logic exp_err, exp_stb;
    idle_cycles(3);
    slave_stall = 1'b1;
    drive_beat(0, mk(0, 1, 32'h800, 0, RESP_ACK), 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (k == TO_CLKS);
`else
      exp_err = 1'b0;
`endif
      exp_stb = ~exp_err;
      checks++;
      if ({gnt_o, m0_err_o, s_stb_o, m1_err_o, m0_ack_o} !== {2'b01, exp_err, exp_stb, 2'b00}) begin
        errors++; $display("FAIL stall_clk%0d got=%b required=%b", k,
                           {gnt_o, m0_err_o, s_stb_o, m1_err_o, m0_ack_o}, {2'b01, exp_err, exp_stb, 2'b00});
      end
    end
    $display("TXN stall m0 adr=00000800 12 clocks");
    @(posedge clk); #1;
    idle_master(0);
    idle_cycles(2);
    slave_stall = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    idle_cycles(2);
    sb_q.push_back(mk(1, 4, 32'h1800, 0, RESP_ACK));
    sb_q.push_back(mk(1, 4, 32'h1800, 1, RESP_ACK));
    for (int b = 0; b < 2; b++) begin
      drive_beat(1, mk(1, 4, 32'h1800, b, RESP_ACK), 1'b1);
      wait_term(1);
      @(posedge clk); #1;
    end
    drive_beat(1, mk(1, 4, 32'h1800, 2, RESP_ACK), 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_outputs got=%b required=0000", {gnt_o, s_cyc_o, s_stb_o});
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) begin
      errors++; $display("FAIL rstmid_terms got=%b required=000000",
                         {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o});
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle_master(1);
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      errors++; $display("FAIL rstmid_after got=%b required=000", {gnt_o, s_cyc_o});
    end
    $display("TXN reset mid-burst m1 adr=00001808");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_burst_lock();
    test_err_rty();
    test_stall_timeout();
    test_reset_mid_burst();
    idle_cycles(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got=%0d pending required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width; select width is DW/8.
REQ-003 Parameter TIMEOUT, 255, stalled-cycle limit in clocks, 1..65535; used only with WB_ARB_TIMEOUT_EN.
REQ-004 Port clk_i, in, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst_i, in, 1, reset, synchronous and active-high.
REQ-006 Ports m0_adr_i/m1_adr_i, in, AW, master address (m0 = LM32 instruction bus, m1 = LM32 data bus).
REQ-007 Ports m0_dat_i/m1_dat_i, in, DW, master write data.
REQ-008 Ports m0_dat_o/m1_dat_o, out, DW, read data; both carry s_dat_i unconditionally.
REQ-009 Ports m0_sel_i/m1_sel_i, in, DW/8, byte selects.
REQ-010 Ports m0_we_i/m1_we_i, m0_cyc_i/m1_cyc_i, m0_stb_i/m1_stb_i, m0_lock_i/m1_lock_i, in, 1 each, Wishbone controls.
REQ-011 Ports m0_cti_i/m1_cti_i, in, 3; m0_bte_i/m1_bte_i, in, 2; burst tags.
REQ-012 Ports m0_ack_o/m1_ack_o, m0_err_o/m1_err_o, m0_rty_o/m1_rty_o, out, 1 each, cycle terminations.
REQ-013 Ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o, out, widths as master side, to the shared slave.
REQ-014 Ports s_dat_i (DW), s_ack_i, s_err_i, s_rty_i (1 each), in, slave responses.
REQ-015 Port gnt_o, out, 2, one-hot current grant (bit0 m0, bit1 m1), 2'b00 when idle.

Function
REQ-016 The FSM SHALL have states IDLE, GNT0, GNT1, held in a register; gnt_o decodes the state.
REQ-017 In IDLE with exactly one mN_cyc_i high, the next state SHALL be GNTN.
REQ-018 In IDLE with both cyc_i high, the grant SHALL go to the master not granted last (round-robin pointer); after reset the pointer favours m0.
REQ-019 In GNTN the grant SHALL hold while mN_cyc_i is high, covering bursts and locked cycles regardless of the other master.
REQ-020 In GNTN with mN_cyc_i low, the next state SHALL be GNT(other) if the other cyc_i is high, else IDLE; no dead cycle on handover.
REQ-021 Arbitration latency SHALL be one clock: s_cyc_o first asserts the cycle after a request from IDLE.
REQ-022 s_* outputs SHALL be a combinational mux of the granted master's inputs, with s_cyc_o = s_stb_o = 0 in IDLE and s_cyc_o/s_stb_o gated by the granted master's cyc_i.
REQ-023 s_ack_i/s_err_i/s_rty_i SHALL route only to the granted master; the other master's terminations SHALL be 0.
REQ-024 The pointer SHALL update to the granted master on every entry into GNT0/GNT1.

Reset
REQ-025 While rst_i is high at a clock edge: state IDLE, pointer favours m0, timeout counter 0.
REQ-026 During and after reset until a grant: gnt_o = 0, s_cyc_o = s_stb_o = 0, all mN_ack_o/err_o/rty_o = 0.
REQ-027 Reset mid-cycle SHALL abandon the cycle with no termination sent to the master.

Configuration
REQ-028 With WB_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count clocks with s_stb_o high and no slave termination, clearing on any termination or grant change.
REQ-029 When the counter reaches TIMEOUT, mN_err_o of the granted master SHALL pulse for one clock, s_stb_o SHALL be 0 that clock, and the counter SHALL clear.
REQ-030 Without WB_ARB_TIMEOUT_EN, no counter SHALL exist and a stalled slave stalls the granted master indefinitely.

Structure
REQ-031 A shared package SHALL hold the state encoding constants (IDLE, GNT0, GNT1) and the CTI/BTE code constants.
REQ-032 The design SHALL be a single module; the timeout counter is inline and needs no sub-module.

Verification
REQ-033 Single request: m0 cyc/stb at cycle 0 to 0x100, slave acks at cycle 2 -> gnt_o = 01 at cycle 1, m0_ack_o at cycle 2, m1_ack_o = 0.
REQ-034 Simultaneous: both cyc high from IDLE after reset -> GNT0 first; after m0 drops cyc, GNT1 the next clock with no IDLE gap.
REQ-035 Round-robin: both request repeatedly with single-beat cycles -> grants alternate 01,10,01,10.
REQ-036 Burst/lock: m1 4-beat burst (cti 010, last 111) with m0 requesting -> m1 holds grant all 4 acks; m0 granted after.
REQ-037 Timeout (macro on, TIMEOUT=8): slave never acks -> granted master sees err on the 8th stalled clock, s_stb_o low that clock.
REQ-038 Reset mid-burst: rst_i high at beat 2 -> next clock gnt_o = 00, s_cyc_o = 0, no ack/err to either master.
